// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 2-bit MAC: clears the accumulator at job start, sums a*b per
// accepted beat, and holds the final sum on a result valid/ready handshake.
module mac_seq_ctrl #(
  parameter int DATA_W = 2,
  parameter int ACC_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len_q, count_q;
  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q, res_valid_q;
  logic                beat, last_beat;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (count_q == len_q - LEN_W'(1));
  assign prod      = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
  // One extra bit captures the carry out of the accumulator for the sticky flag.
  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      // Abort takes priority over a final beat in the same cycle.
      RUN:     if (abort) state_nxt = IDLE;
               else if (last_beat) state_nxt = DONE;
      DONE:    if (res_valid_q && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!abort && beat) begin
            acc_q   <= sum[ACC_W-1:0];
            ovf_q   <= ovf_q | sum[ACC_W];
            count_q <= count_q + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized and directed bench for mac_seq_ctrl; runs an 8-bit and a 4-bit
// accumulator instance side by side against an arithmetic reference model.
module tb_mac_seq_ctrl;

  logic       clk, rst, start, abort, in_valid, res_ready;
  logic [3:0] len;
  logic [1:0] a_in, b_in;

  logic       in_ready8, res_valid8, overflow8, busy8;
  logic [7:0] result8;
  logic       in_ready4, res_valid4, overflow4, busy4;
  logic [3:0] result4;

  int errors = 0;
  int checks = 0;
  int qa[$];
  int qb[$];

  mac_seq_ctrl #(.DATA_W(2), .ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready8), .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid8), .res_ready(res_ready), .result(result8),
    .overflow(overflow8), .busy(busy8)
  );

  mac_seq_ctrl #(.DATA_W(2), .ACC_W(4), .LEN_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready4), .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid4), .res_ready(res_ready), .result(result4),
    .overflow(overflow4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product of the queued operand pairs, wrapped to w bits; ovf notes any wrap.
  function automatic void model(input int n, input int w, output int res, output bit ovf);
    int m = 1 << w;
    int s = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + qa[i] * qb[i];
      if (s >= m) begin
        ovf = 1'b1;
        s   = s - m;
      end
    end
    res = s;
  endfunction

  // vmode: 0 valid held high, 1 toggling 1,0,1..., 2 random.
  task automatic run_job(input int n, input int vmode, input int hold,
                         input bit start_in_run, input bit start_on_hs, input string tag);
    int  idx = 0;
    int  cyc = 0;
    int  e8, e4;
    bit  o8, o4;
    bit  v;
    checks++;
    if (in_ready8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before_start: in_ready=%b busy=%b required 0 0", tag, in_ready8, busy8);
    end
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = start_in_run;
    len   = 4'(n ^ 5);
    while (idx < n) begin
      if (cyc > 200) begin
        errors++;
        checks++;
        $display("FAIL %s beat_timeout: accepted %0d of %0d beats", tag, idx, n);
        break;
      end
      checks++;
      if (in_ready8 !== 1'b1 || in_ready4 !== 1'b1 || res_valid8 !== 1'b0 || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL %s run_state: in_ready=%b/%b res_valid=%b busy=%b required 1/1 0 1",
                 tag, in_ready8, in_ready4, res_valid8, busy8);
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      a_in     = 2'(qa[idx]);
      b_in     = 2'(qb[idx]);
      tick();
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    model(n, 8, e8, o8);
    model(n, 4, e4, o4);
    checks++;
    if (res_valid8 !== 1'b1 || res_valid4 !== 1'b1 || in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: res_valid=%b/%b in_ready=%b required 1/1 0",
               tag, res_valid8, res_valid4, in_ready8);
    end
    checks++;
    if (result8 !== 8'(e8) || overflow8 !== o8) begin
      errors++;
      $display("FAIL %s result8: got %0d ovf=%b required %0d ovf=%b", tag, result8, overflow8, e8, o8);
    end
    checks++;
    if (result4 !== 4'(e4) || overflow4 !== o4) begin
      errors++;
      $display("FAIL %s result4: got %0d ovf=%b required %0d ovf=%b", tag, result4, overflow4, e4, o4);
    end
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      tick();
      checks++;
      if (res_valid8 !== 1'b1 || result8 !== 8'(e8) || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL %s hold_%0d: res_valid=%b result=%0d busy=%b required 1 %0d 1",
                 tag, h, res_valid8, result8, busy8, e8);
      end
    end
    res_ready = 1'b1;
    if (start_on_hs) begin
      start = 1'b1;
      len   = 4'd2;
    end
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if (res_valid8 !== 1'b0 || busy8 !== 1'b0 || busy4 !== 1'b0 || in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake: res_valid=%b busy=%b/%b in_ready=%b required 0 0/0 0",
               tag, res_valid8, busy8, busy4, in_ready8);
    end
    if (start_on_hs) begin
      tick();
      checks++;
      if (busy8 !== 1'b0 || in_ready8 !== 1'b0 || res_valid8 !== 1'b0) begin
        errors++;
        $display("FAIL %s hs_start_ignored: busy=%b in_ready=%b res_valid=%b required 0 0 0",
                 tag, busy8, in_ready8, res_valid8);
      end
    end
  endtask

  task automatic set_ops(input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int n);
    qa = {a0, a1, a2};
    qb = {b0, b1, b2};
    while (qa.size() > n) begin
      void'(qa.pop_back());
      void'(qb.pop_back());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready8 !== 1'b0 || res_valid8 !== 1'b0 || result8 !== 8'd0 ||
        overflow8 !== 1'b0 || busy8 !== 1'b0 || result4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b res_valid=%b result=%0d ovf=%b busy=%b required all 0",
               in_ready8, res_valid8, result8, overflow8, busy8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_ops(3, 3, 2, 1, 1, 1, 3);
    run_job(3, 0, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    set_ops(3, 3, 2, 1, 1, 1, 3);
    run_job(3, 1, 4, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_overflow();
    set_ops(3, 3, 3, 3, 0, 0, 2);
    run_job(2, 0, 0, 1'b0, 1'b0, "overflow");
    set_ops(1, 1, 0, 0, 0, 0, 1);
    run_job(1, 0, 0, 1'b0, 1'b0, "overflow_cleared");
  endtask

  task automatic test_len_zero();
    qa.delete();
    qb.delete();
    run_job(0, 0, 1, 1'b0, 1'b0, "len_zero");
  endtask

  task automatic test_abort();
    start = 1'b1;
    len   = 4'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 2'd1;
    b_in     = 2'd1;
    tick();
    a_in  = 2'd3;
    b_in  = 2'd3;
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b0 || res_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_idle: busy=%b in_ready=%b res_valid=%b required 0 0 0",
               busy8, in_ready8, res_valid8);
    end
    for (int i = 0; i < 3; i++) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (res_valid8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_result_%0d: res_valid=%b busy=%b required 0 0", i, res_valid8, busy8);
      end
    end
    set_ops(2, 3, 0, 0, 0, 0, 1);
    run_job(1, 0, 0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    len   = 4'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 2'd3;
    b_in     = 2'd3;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b0 || res_valid8 !== 1'b0 ||
        result8 !== 8'd0 || overflow8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b in_ready=%b res_valid=%b result=%0d ovf=%b required all 0",
               busy8, in_ready8, res_valid8, result8, overflow8);
    end
    #1;
    rst = 1'b0;
    tick();
    start = 1'b1;
    len   = 4'd1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 2'd2;
    b_in     = 2'd2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (res_valid8 !== 1'b1 || result8 !== 8'd4) begin
      errors++;
      $display("FAIL pre_rst_done: res_valid=%b result=%0d required 1 4", res_valid8, result8);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b0 || res_valid8 !== 1'b0 ||
        result8 !== 8'd0 || overflow8 !== 1'b0 || result4 !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_done: busy=%b in_ready=%b res_valid=%b result=%0d ovf=%b required all 0",
               busy8, in_ready8, res_valid8, result8, overflow8);
    end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    set_ops(1, 2, 3, 1, 2, 2, 3);
    run_job(3, 0, 1, 1'b1, 1'b1, "start_ignored");
  endtask

  task automatic test_random();
    for (int j = 0; j < 40; j++) begin
      int n = $urandom_range(0, 15);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back($urandom_range(0, 3));
        qb.push_back($urandom_range(0, 3));
      end
      run_job(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $sformatf("random_%0d", j));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    a_in      = 2'd0;
    b_in      = 2'd0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_len_zero();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
